tmds_channel_rx: RTL

Receive-side counterpart of the HDMI transmit path: one TMDS channel at the pixel clock. Input is a raw, word-unaligned 10-bit parallel stream from an external 1:10 deserializer. The block finds the word boundary by bit-slipping until it sees runs of control tokens, then decodes each word into 8-bit video data or a 2-bit control value with a data-enable. It also emits hsync/vsync and end-of-line strobes; these are meaningful on the blue channel, which carries {vSync,hSync}. Three instances form the DVI receiver.

---
 rtl/tmds_channel_rx.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/tmds_channel_rx.sv
// One TMDS receive channel. It bit-slips the raw 10-bit stream until runs of control
// tokens line up, then decodes each word into video data or a 2-bit control value.
module tmds_channel_rx #(
  parameter int LOCK_RUN = 12,
  parameter int WINDOW   = 1024
) (
  input  logic       i_pixclk,
  input  logic       i_reset,
  input  logic [9:0] i_word,
  output logic       o_locked,
  output logic [3:0] o_offset,
  output logic       o_de,
  output logic [7:0] o_data,
  output logic [1:0] o_ctrl,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_newline
);
  localparam int RUN_W = $clog2(LOCK_RUN + 1);
  localparam int WIN_W = $clog2(WINDOW);
  localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(LOCK_RUN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

  function automatic logic is_token(input logic [9:0] w);
    return (w == 10'b1101010100) || (w == 10'b0010101011) ||
           (w == 10'b0101010100) || (w == 10'b1010101011);
  endfunction

  function automatic logic [1:0] token_ctrl(input logic [9:0] w);
    logic [1:0] c;
    case (w)
      10'b0010101011: c = 2'b01;
      10'b0101010100: c = 2'b10;
      10'b1010101011: c = 2'b11;
      default:        c = 2'b00;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] w);
    logic [7:0] q;
    logic [7:0] d;
    q    = w[9] ? ~w[7:0] : w[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  state_t           state_q,      state_d;
  logic             locked_q,     locked_d;
  logic [3:0]       offset_q,     offset_d;
  logic [RUN_W-1:0] run_q,        run_d;
  logic [WIN_W-1:0] win_q,        win_d;
  logic [1:0]       flush_q,      flush_d;
  logic             seen_q,       seen_d;
  logic [9:0]       prev_p0_q,    prev_p0_d;
  logic [9:0]       aligned_p1_q, aligned_p1_d;
  logic             de_p2_q,      de_p2_d;
  logic [7:0]       data_p2_q,    data_p2_d;
  logic [1:0]       ctrl_p2_q,    ctrl_p2_d;
  logic             de_p3_q,      de_p3_d;
  logic             newline_q,    newline_d;

  logic [18:0] window_bits;
  logic        run_hit;
  logic        win_exp;
  logic        slip;

  // Stage p0 -> p1: select the 10-bit window at the current slip offset.
  always_comb begin
    prev_p0_d   = i_word;
    window_bits = {i_word[8:0], prev_p0_q};
    case (offset_q)
      4'd1:    aligned_p1_d = window_bits[10:1];
      4'd2:    aligned_p1_d = window_bits[11:2];
      4'd3:    aligned_p1_d = window_bits[12:3];
      4'd4:    aligned_p1_d = window_bits[13:4];
      4'd5:    aligned_p1_d = window_bits[14:5];
      4'd6:    aligned_p1_d = window_bits[15:6];
      4'd7:    aligned_p1_d = window_bits[16:7];
      4'd8:    aligned_p1_d = window_bits[17:8];
      4'd9:    aligned_p1_d = window_bits[18:9];
      default: aligned_p1_d = window_bits[9:0];
    endcase
  end

  // Alignment control: lock on a token run, otherwise slip once per window.
  always_comb begin
    run_hit  = (run_q == RUN_FULL);
    win_exp  = (win_q == WIN_LAST);
    slip     = 1'b0;
    state_d  = state_q;
    seen_d   = seen_q;
    win_d    = win_exp ? '0 : win_q + WIN_W'(1);
    offset_d = offset_q;
    flush_d  = (flush_q != 2'd0) ? flush_q - 2'd1 : 2'd0;
    case (state_q)
      ST_SEARCH: begin
        if (run_hit) begin
          state_d = ST_LOCKED;
          seen_d  = 1'b1;
          win_d   = '0;
        end else if (win_exp) begin
          slip = 1'b1;
        end
      end
      default: begin
        if (win_exp) begin
          seen_d = 1'b0;
          if (!(seen_q || run_hit)) begin
            slip    = 1'b1;
            state_d = ST_SEARCH;
          end
        end else if (run_hit) begin
          seen_d = 1'b1;
        end
      end
    endcase
    if (slip) begin
      offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
      win_d    = '0;
      flush_d  = 2'd2;
    end
    // Words already in the pipe were cut at the old offset; keep them out of the run.
    if (slip || (flush_q != 2'd0)) begin
      run_d = '0;
    end else if (is_token(aligned_p1_q)) begin
      run_d = run_hit ? run_q : run_q + RUN_W'(1);
    end else begin
      run_d = '0;
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // Stage p1 -> p2: decode; p2 -> p3: end-of-line edge detect.
  always_comb begin
    de_p2_d   = 1'b0;
    data_p2_d = '0;
    ctrl_p2_d = '0;
    if (state_q == ST_LOCKED) begin
      data_p2_d = data_p2_q;
      ctrl_p2_d = ctrl_p2_q;
      if (is_token(aligned_p1_q)) begin
        ctrl_p2_d = token_ctrl(aligned_p1_q);
      end else begin
        de_p2_d   = 1'b1;
        data_p2_d = tmds_decode(aligned_p1_q);
      end
    end
    de_p3_d   = de_p2_q;
    newline_d = de_p3_q & ~de_p2_q;
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      state_q      <= ST_SEARCH;
      locked_q     <= 1'b0;
      offset_q     <= 4'd0;
      run_q        <= '0;
      win_q        <= '0;
      flush_q      <= 2'd0;
      seen_q       <= 1'b0;
      prev_p0_q    <= '0;
      aligned_p1_q <= '0;
      de_p2_q      <= 1'b0;
      data_p2_q    <= '0;
      ctrl_p2_q    <= '0;
      de_p3_q      <= 1'b0;
      newline_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      locked_q     <= locked_d;
      offset_q     <= offset_d;
      run_q        <= run_d;
      win_q        <= win_d;
      flush_q      <= flush_d;
      seen_q       <= seen_d;
      prev_p0_q    <= prev_p0_d;
      aligned_p1_q <= aligned_p1_d;
      de_p2_q      <= de_p2_d;
      data_p2_q    <= data_p2_d;
      ctrl_p2_q    <= ctrl_p2_d;
      de_p3_q      <= de_p3_d;
      newline_q    <= newline_d;
    end
  end

  assign o_locked  = locked_q;
  assign o_offset  = offset_q;
  assign o_de      = de_p2_q;
  assign o_data    = data_p2_q;
  assign o_ctrl    = ctrl_p2_q;
  assign o_hsync   = ctrl_p2_q[0];
  assign o_vsync   = ctrl_p2_q[1];
  assign o_newline = newline_q;

endmodule
